tb_offchip_mem: RTL and testbench

TB_OFFCHIP_MEM -- requirements
Module: tb_offchip_mem

---
 rtl/tb_mem_pkg.sv | 27 ++
 rtl/tb_mem_channel_ctrl.sv | 65 ++++++
 rtl/tb_offchip_mem.sv | 107 ++++++++++
 tb/tb_tb_offchip_mem.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tb_mem_pkg.sv
// Shared definitions for the off-chip memory model: latency limits, default
// parameters and the access-size to bit-mask helper.
package tb_mem_pkg;

  localparam int READ_LAT_MIN  = 2;
  localparam int READ_LAT_MAX  = 15;
  localparam int WRITE_LAT_MIN = 1;
  localparam int WRITE_LAT_MAX = 15;
  localparam int LAT_CNT_W     = 4;

  localparam int DEF_N_CH      = 2;
  localparam int DEF_ADDR_W    = 7;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_SIZE_W    = 4;
  localparam int DEF_MEM_BYTES = 32;
  localparam int DEF_READ_LAT  = 2;
  localparam int DEF_WRITE_LAT = 1;

  // Widest data path the mask helper supports; callers truncate to DATA_W.
  localparam int MASK_W = 256;

  function automatic logic [MASK_W-1:0] size_to_mask(input int unsigned size);
    if (size >= MASK_W) return '1;
    return (MASK_W'(1) << size) - MASK_W'(1);
  endfunction

endpackage

// File: rtl/tb_mem_channel_ctrl.sv
// One memory channel: latency counter, ready generation, write-commit strobe
// and the read-data pipeline whose head is ORed with the on-chip slave return.
module tb_mem_channel_ctrl
  import tb_mem_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int READ_LAT  = DEF_READ_LAT,
  parameter int WRITE_LAT = DEF_WRITE_LAT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rd_req,
  input  logic              wr_req,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic              s_rdy,
  output logic [DATA_W-1:0] m_rdata,
  output logic              m_rdy,
  output logic              wr_commit
);

  localparam logic [LAT_CNT_W-1:0] RD_LAST = LAT_CNT_W'(READ_LAT - 1);
  localparam logic [LAT_CNT_W-1:0] WR_LAST = LAT_CNT_W'(WRITE_LAT - 1);

  logic [LAT_CNT_W-1:0] cnt;
  logic                 active;
  logic                 model_rdy;
  logic [DATA_W-1:0]    pipe [READ_LAT-1];

  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    active    = rd_req | wr_req;
    model_rdy = 1'b0;
    if (!reset && active)
      model_rdy = rd_req ? (cnt == RD_LAST) : (cnt == WR_LAST);
    wr_commit = wr_req & model_rdy;
    m_rdy     = model_rdy | s_rdy;
    m_rdata   = pipe[READ_LAT-2] | s_rdata;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (active && !model_rdy) begin
      cnt <= cnt + LAT_CNT_W'(1);
    end else begin
      cnt <= '0;
    end
  end

  // Shifts every cycle; data sampled in request cycle 1 reaches the head in
  // cycle READ_LAT, exactly when ready asserts.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < READ_LAT - 1; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= rd_req ? mem_rdata : '0;
      for (int i = 1; i < READ_LAT - 1; i++) pipe[i] <= pipe[i-1];
    end
  end

endmodule

// File: rtl/tb_offchip_mem.sv
// Multi-channel off-chip memory model: window decode, byte array with preload
// port, prioritised byte-lane write merge and sticky protocol error.
module tb_offchip_mem
  import tb_mem_pkg::*;
#(
  parameter int N_CH      = DEF_N_CH,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int SIZE_W    = DEF_SIZE_W,
  parameter int MEM_BYTES = DEF_MEM_BYTES,
  parameter int READ_LAT  = DEF_READ_LAT,
  parameter int WRITE_LAT = DEF_WRITE_LAT
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [ADDR_W-1:0]        base_addr,
  input  logic [N_CH-1:0]          m_oe,
  input  logic [N_CH-1:0]          m_we,
  input  logic [N_CH*ADDR_W-1:0]   m_addr,
  input  logic [N_CH*DATA_W-1:0]   m_wdata,
  input  logic [N_CH*SIZE_W-1:0]   m_size,
  input  logic [N_CH*DATA_W-1:0]   s_rdata,
  input  logic [N_CH-1:0]          s_rdy,
  input  logic                     ld_en,
  input  logic [ADDR_W-1:0]        ld_addr,
  input  logic [7:0]               ld_data,
  output logic [N_CH*DATA_W-1:0]   m_rdata,
  output logic [N_CH-1:0]          m_rdy,
  output logic                     err
);

  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;

  if (READ_LAT < READ_LAT_MIN || READ_LAT > READ_LAT_MAX ||
      WRITE_LAT < WRITE_LAT_MIN || WRITE_LAT > WRITE_LAT_MAX) begin : g_bad_lat
    $error("tb_offchip_mem: latency parameter out of range");
  end

  logic [7:0]        mem       [MEM_BYTES];
  logic [N_CH-1:0]   in_win;
  logic [N_CH-1:0]   rd_req;
  logic [N_CH-1:0]   wr_req;
  logic [N_CH-1:0]   wr_commit;
  logic [DATA_W-1:0] mem_rdata [N_CH];
  logic [IDX_W-1:0]  byte_idx  [N_CH][NB];
  logic [7:0]        merged    [N_CH][NB];

  // Window test uses 32-bit arithmetic so an access running past the top of
  // the address space counts as out-of-window instead of wrapping.
  always_comb begin
    logic [31:0]       a;
    logic [31:0]       b;
    logic [31:0]       off;
    logic [DATA_W-1:0] mask;
    b = 32'(base_addr);
    for (int c = 0; c < N_CH; c++) begin
      a         = 32'(m_addr[c*ADDR_W +: ADDR_W]);
      off       = a - b;
      mask      = DATA_W'(size_to_mask(32'(m_size[c*SIZE_W +: SIZE_W])));
      in_win[c] = (a >= b) && (a + 32'(NB) <= b + 32'(MEM_BYTES));
      rd_req[c] = m_oe[c] & in_win[c];
      wr_req[c] = m_we[c] & ~m_oe[c] & in_win[c];
      for (int i = 0; i < NB; i++) begin
        byte_idx[c][i]         = IDX_W'(off + 32'(i));
        mem_rdata[c][8*i +: 8] = in_win[c] ? mem[byte_idx[c][i]] : 8'h00;
        merged[c][i] = (m_wdata[c*DATA_W + 8*i +: 8] & mask[8*i +: 8]) |
                       (mem[byte_idx[c][i]] & ~mask[8*i +: 8]);
      end
    end
  end

  // NOTE: the byte array deliberately has no reset so preloaded contents
  // survive it. Later assignments in this block win: ld < ch0 < ch1 < ...
  always_ff @(posedge clock) begin
    if (ld_en && (32'(ld_addr) < 32'(MEM_BYTES)))
      mem[IDX_W'(ld_addr)] <= ld_data;
    for (int c = 0; c < N_CH; c++)
      for (int i = 0; i < NB; i++)
        if (wr_commit[c]) mem[byte_idx[c][i]] <= merged[c][i];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)              err <= 1'b0;
    else if (|(m_oe & m_we)) err <= 1'b1;
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    tb_mem_channel_ctrl #(
      .DATA_W    (DATA_W),
      .READ_LAT  (READ_LAT),
      .WRITE_LAT (WRITE_LAT)
    ) u_ctrl (
      .clock     (clock),
      .reset     (reset),
      .rd_req    (rd_req[c]),
      .wr_req    (wr_req[c]),
      .mem_rdata (mem_rdata[c]),
      .s_rdata   (s_rdata[c*DATA_W +: DATA_W]),
      .s_rdy     (s_rdy[c]),
      .m_rdata   (m_rdata[c*DATA_W +: DATA_W]),
      .m_rdy     (m_rdy[c]),
      .wr_commit (wr_commit[c])
    );
  end

endmodule

// File: tb/tb_tb_offchip_mem.sv
// Self-checking bench for tb_offchip_mem at default parameters: directed
// scenarios followed by random traffic against a byte-array reference model.
module tb_tb_offchip_mem;

  localparam int N_CH      = 2;
  localparam int ADDR_W    = 7;
  localparam int DATA_W    = 8;
  localparam int SIZE_W    = 4;
  localparam int MEM_BYTES = 32;
  localparam int READ_LAT  = 2;

  logic                   clock = 1'b0;
  logic                   reset;
  logic [ADDR_W-1:0]      base_addr;
  logic [N_CH-1:0]        m_oe, m_we, s_rdy, m_rdy;
  logic [N_CH*ADDR_W-1:0] m_addr;
  logic [N_CH*DATA_W-1:0] m_wdata, s_rdata, m_rdata;
  logic [N_CH*SIZE_W-1:0] m_size;
  logic                   ld_en;
  logic [ADDR_W-1:0]      ld_addr;
  logic [7:0]             ld_data;
  logic                   err;

  logic [7:0] model_mem [MEM_BYTES];
  int checks = 0;
  int errors = 0;

  tb_offchip_mem dut (
    .clock(clock), .reset(reset), .base_addr(base_addr),
    .m_oe(m_oe), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_size(m_size), .s_rdata(s_rdata), .s_rdy(s_rdy),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .m_rdata(m_rdata), .m_rdy(m_rdy), .err(err)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_reqs();
    m_oe = '0; m_we = '0; s_rdy = '0; s_rdata = '0; ld_en = 1'b0;
  endtask

  function automatic bit in_window(input logic [ADDR_W-1:0] a);
    return int'(a) >= int'(base_addr) && int'(a) < int'(base_addr) + MEM_BYTES;
  endfunction

  task automatic preload(input int off, input logic [7:0] val);
    next_cycle();
    clear_reqs();
    ld_en = 1'b1; ld_addr = ADDR_W'(off); ld_data = val;
    if (off < MEM_BYTES) model_mem[off] = val;
  endtask

  // In-window read held until ready; ready expected exactly in cycle READ_LAT.
  task automatic run_read(input int c, input logic [ADDR_W-1:0] a, input string tag);
    for (int k = 1; k <= READ_LAT; k++) begin
      next_cycle();
      clear_reqs();
      m_oe[c] = 1'b1; m_addr[c*ADDR_W +: ADDR_W] = a;
      #1;
      check({tag, "_rdy"}, 32'(m_rdy), (k == READ_LAT) ? (32'd1 << c) : 32'd0);
      if (k == READ_LAT)
        check({tag, "_data"}, 32'(m_rdata[c*DATA_W +: DATA_W]),
              32'(model_mem[int'(a) - int'(base_addr)]));
    end
  endtask

  // In-window write with write latency 1: ready in cycle 1, memory updates at its edge.
  task automatic run_write(input int c, input logic [ADDR_W-1:0] a,
                           input logic [7:0] d, input logic [3:0] sz, input string tag);
    logic [7:0] mask;
    int idx;
    next_cycle();
    clear_reqs();
    m_we[c] = 1'b1; m_addr[c*ADDR_W +: ADDR_W] = a;
    m_wdata[c*DATA_W +: DATA_W] = d; m_size[c*SIZE_W +: SIZE_W] = sz;
    #1;
    check({tag, "_rdy"}, 32'(m_rdy), 32'd1 << c);
    mask = (sz >= 8) ? 8'hFF : 8'((1 << sz) - 1);
    idx = int'(a) - int'(base_addr);
    model_mem[idx] = (d & mask) | (model_mem[idx] & ~mask);
  endtask

  // Out-of-window request completed by the on-chip slave in cycle d (d >= 2).
  task automatic run_ext(input int c, input logic [ADDR_W-1:0] a, input bit wr,
                         input int d, input logic [7:0] sd, input string tag);
    for (int k = 1; k <= d; k++) begin
      next_cycle();
      clear_reqs();
      if (wr) m_we[c] = 1'b1; else m_oe[c] = 1'b1;
      m_addr[c*ADDR_W +: ADDR_W] = a;
      m_wdata[c*DATA_W +: DATA_W] = ~sd; m_size[c*SIZE_W +: SIZE_W] = 4'd8;
      if (k == d) begin
        s_rdy[c] = 1'b1; s_rdata[c*DATA_W +: DATA_W] = sd;
      end
      #1;
      check({tag, "_rdy"}, 32'(m_rdy), (k == d) ? (32'd1 << c) : 32'd0);
      if (k == d)
        check({tag, "_data"}, 32'(m_rdata[c*DATA_W +: DATA_W]), 32'(sd));
    end
  endtask

  initial begin
    logic [ADDR_W-1:0] a;
    int c;
    reset = 1'b1; base_addr = 7'h10;
    clear_reqs();
    m_addr = {7'h10, 7'h10}; m_wdata = '0; m_size = '0;
    ld_addr = '0; ld_data = '0;
    m_we = 2'b11;
    next_cycle();
    next_cycle();
    #1;
    check("reset_rdy", 32'(m_rdy), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    check("reset_rdata", 32'(m_rdata), 32'd0);
    clear_reqs();
    next_cycle();
    reset = 1'b0;

    for (int off = 0; off < MEM_BYTES; off++) begin
      if (off == 5)      preload(off, 8'hA5);
      else if (off == 2) preload(off, 8'h30);
      else if (off == 3) preload(off, 8'h5C);
      else               preload(off, 8'($urandom));
    end
    preload(40, 8'hE7);
    next_cycle();
    clear_reqs();

    run_read(0, 7'h15, "rd_a5");
    run_write(1, 7'h12, 8'hFF, 4'd4, "wr_nib");
    run_read(1, 7'h12, "rb_nib");

    next_cycle();
    clear_reqs();
    m_we = 2'b11; m_addr = {7'h11, 7'h11}; m_wdata = {8'h02, 8'h01}; m_size = {4'd8, 4'd8};
    #1;
    check("wr_both_rdy", 32'(m_rdy), 32'h3);
    model_mem[1] = 8'h02;
    run_read(0, 7'h11, "rb_both");

    run_ext(0, 7'h40, 1'b0, 3, 8'h77, "ext_rd");
    next_cycle();
    clear_reqs();
    m_oe[0] = 1'b1;
    #1;
    check("ext_after_rdy", 32'(m_rdy), 32'd0);
    check("ext_after_data", 32'(m_rdata), 32'd0);

    // Dropped request: the reissue must restart the latency count.
    next_cycle();
    clear_reqs();
    m_oe[1] = 1'b1; m_addr[ADDR_W +: ADDR_W] = 7'h18;
    #1;
    check("drop_c1_rdy", 32'(m_rdy), 32'd0);
    next_cycle();
    clear_reqs();
    #1;
    check("drop_gap_rdy", 32'(m_rdy), 32'd0);
    run_read(1, 7'h18, "reissue");

    next_cycle();
    clear_reqs();
    m_oe[0] = 1'b1; m_we[0] = 1'b1; m_addr[0 +: ADDR_W] = 7'h15;
    m_wdata[0 +: DATA_W] = 8'hEE; m_size[0 +: SIZE_W] = 4'd8;
    #1;
    check("err_before", 32'(err), 32'd0);
    next_cycle();
    clear_reqs();
    #1;
    check("err_set", 32'(err), 32'd1);
    repeat (3) next_cycle();
    check("err_sticky", 32'(err), 32'd1);
    run_read(0, 7'h15, "err_no_write");
    next_cycle();
    clear_reqs();
    reset = 1'b1;
    #1;
    check("err_reset", 32'(err), 32'd0);
    next_cycle();
    reset = 1'b0;

    next_cycle();
    clear_reqs();
    m_we[0] = 1'b1; m_addr[0 +: ADDR_W] = 7'h13;
    m_wdata[0 +: DATA_W] = 8'hC3; m_size[0 +: SIZE_W] = 4'd8;
    #1;
    reset = 1'b1;
    #1;
    check("rst_wr_rdy", 32'(m_rdy), 32'd0);
    check("rst_wr_err", 32'(err), 32'd0);
    next_cycle();
    reset = 1'b0;
    clear_reqs();
    run_read(1, 7'h13, "rst_wr_rb");

    // Back-to-back random traffic, two window positions.
    for (int t = 0; t < 80; t++) begin
      if (t == 40) base_addr = 7'h20;
      c = $urandom_range(0, 1);
      a = ADDR_W'($urandom_range(int'(base_addr) - 4, int'(base_addr) + MEM_BYTES + 4));
      if (in_window(a)) begin
        if ($urandom_range(0, 1) == 1) run_read(c, a, "rnd_rd");
        else run_write(c, a, 8'($urandom), 4'($urandom_range(0, 15)), "rnd_wr");
      end else begin
        run_ext(c, a, 1'($urandom_range(0, 1)), $urandom_range(2, 3),
                8'($urandom), "rnd_ext");
      end
    end

    base_addr = 7'h10;
    for (int off = 0; off < MEM_BYTES; off++)
      run_read(off % 2, ADDR_W'(16 + off), "sweep");
    next_cycle();
    clear_reqs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
